sdram_port_arbiter: RTL

Multi-port successor to the single read/write SDRAM facade. It arbitrates `NumPorts` independent burst clients onto one SDRAM controller command interface, using round-robin fairness. Each port owns a private frame region with its own auto-incrementing, wrapping address pointer. A port can request either a read or a write on any burst. The block sits between frame producers/consumers (UART capture, VGA scan-out, scaler) and the SDRAM controller.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/round_robin_picker.sv | 28 ++
 rtl/sdram_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and size derivations for the multi-port SDRAM arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, END} arb_state_t;

   function automatic int frame_size(input int width, input int height);
      return width * height;
   endfunction

   // PTR_W: enough bits to hold any in-frame word offset
   function automatic int ptr_width(input int fsize);
      return (fsize > 1) ? $clog2(fsize) : 1;
   endfunction

   // One extra bit so a full burst count is representable
   function automatic int beat_cnt_width(input int burst_len);
      return $clog2(burst_len) + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin pick: first requester searching upward from last+1.
module round_robin_picker
   import sdram_arb_pkg::*;
#(
   parameter int NumPorts = 2
) (
   input  logic [NumPorts-1:0]              i_req,
   input  logic [idx_width(NumPorts)-1:0]   i_last,
   output logic [NumPorts-1:0]              o_gnt,
   output logic [idx_width(NumPorts)-1:0]   o_idx,
   output logic                             o_any
);
   localparam int IW = idx_width(NumPorts);

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int i = 1; i <= NumPorts; i++) begin
         if (!o_any && i_req[(int'(i_last) + i) % NumPorts]) begin
            o_any = 1'b1;
            o_gnt[(int'(i_last) + i) % NumPorts] = 1'b1;
            o_idx = IW'((int'(i_last) + i) % NumPorts);
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter of burst clients onto one SDRAM controller, with a
// private wrapping frame pointer per port.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NumPorts          = 2,
   parameter int FrameWidth        = 640,
   parameter int FrameHeight       = 480,
   parameter int BurstLengthSDRAM  = 8,
   parameter int PixelBitWidth     = 16,
   parameter int AddressWidthSDRAM = 24
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [NumPorts-1:0]                i_req,
   input  logic [NumPorts-1:0]                i_rd,
   input  logic [NumPorts-1:0]                i_restart,
   input  logic [NumPorts*PixelBitWidth-1:0]  i_wdata,
   output logic [NumPorts-1:0]                o_wready,
   output logic [PixelBitWidth-1:0]           o_rdata,
   output logic [NumPorts-1:0]                o_rvalid,
   output logic [NumPorts-1:0]                o_grant,
   output logic [NumPorts-1:0]                o_done,
   output logic [NumPorts-1:0]                o_err,
   input  logic                               i_sdram_busy,
   input  logic                               i_sdram_valid_wr,
   input  logic                               i_sdram_valid_rd,
   input  logic [PixelBitWidth-1:0]           i_sdram_pixel,
   output logic                               o_sdram_enable,
   output logic                               o_sdram_read,
   output logic [PixelBitWidth-1:0]           o_sdram_pixel,
   output logic [AddressWidthSDRAM-1:0]       o_sdram_addr
);
   localparam int FS = frame_size(FrameWidth, FrameHeight);
   localparam int PW = ptr_width(FS);
   localparam int CW = beat_cnt_width(BurstLengthSDRAM);
   localparam int IW = idx_width(NumPorts);

   arb_state_t                     state, state_nxt;
   logic [IW-1:0]                  last, gidx, pick_idx;
   logic [NumPorts-1:0]            pick_gnt, rst_pend;
   logic                           pick_any, rd_lat, start, beat, full;
   logic [CW-1:0]                  cnt;
   logic [NumPorts-1:0][PW-1:0]    ptr;
   logic [PW:0]                    ptr_sum;

   round_robin_picker #(.NumPorts(NumPorts)) u_pick (
      .i_req  (i_req),
      .i_last (last),
      .o_gnt  (pick_gnt),
      .o_idx  (pick_idx),
      .o_any  (pick_any)
   );

   assign start   = (state == IDLE) && !i_sdram_busy && pick_any;
   assign beat    = (state == XFER) && (rd_lat ? i_sdram_valid_rd : i_sdram_valid_wr);
   assign full    = (cnt == CW'(BurstLengthSDRAM));
   assign ptr_sum = {1'b0, ptr[gidx]} + (PW+1)'(BurstLengthSDRAM);

   always_ff @(posedge CLK) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (i_sdram_busy) state_nxt = XFER;
         XFER:    if (!i_sdram_busy) state_nxt = END;
         END:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         o_grant        <= '0;
         o_done         <= '0;
         o_err          <= '0;
         o_rvalid       <= '0;
         o_rdata        <= '0;
         o_sdram_enable <= 1'b0;
         o_sdram_read   <= 1'b0;
         gidx           <= '0;
         rd_lat         <= 1'b0;
         cnt            <= '0;
         rst_pend       <= '0;
         ptr            <= '0;
         last           <= IW'(NumPorts - 1);
      end else begin
         o_done   <= '0;
         o_err    <= '0;
         o_rvalid <= '0;
         // A restart on the owning port must not race the END pointer update
         rst_pend <= (state == END) ? '0 : (rst_pend | (i_restart & o_grant));
         for (int q = 0; q < NumPorts; q++)
            if (i_restart[q] && !o_grant[q]) ptr[q] <= '0;
         case (state)
            IDLE: if (start) begin
               o_grant        <= pick_gnt;
               gidx           <= pick_idx;
               rd_lat         <= i_rd[pick_idx];
               o_sdram_read   <= i_rd[pick_idx];
               o_sdram_enable <= 1'b1;
               cnt            <= '0;
            end
            ISSUE: if (i_sdram_busy) begin
               o_sdram_enable <= 1'b0;
               o_sdram_read   <= 1'b0;
            end
            XFER: begin
               if (beat && !full) cnt <= cnt + 1'b1;
               if (rd_lat && i_sdram_valid_rd) begin
                  o_rdata  <= i_sdram_pixel;
                  o_rvalid <= o_grant;
               end
            end
            END: begin
               if (full) o_done <= o_grant;
               else      o_err  <= o_grant;
               if (rst_pend[gidx] || i_restart[gidx]) ptr[gidx] <= '0;
               else if (full) ptr[gidx] <= (ptr_sum == (PW+1)'(FS)) ? '0 : ptr_sum[PW-1:0];
               o_grant <= '0;
               last    <= gidx;
            end
            default: ;
         endcase
      end
   end

   assign o_wready      = (state == XFER && !rd_lat && i_sdram_valid_wr) ? o_grant : '0;
   assign o_sdram_pixel = (state == XFER && !rd_lat) ?
                          i_wdata[int'(gidx)*PixelBitWidth +: PixelBitWidth] : '0;
   assign o_sdram_addr  = (state == ISSUE) ?
                          AddressWidthSDRAM'(int'(gidx) * FS) + AddressWidthSDRAM'(ptr[gidx]) : '0;

endmodule
